// File: rtl/pipelined_control_unit_if.sv
// rtl/pipelined_control_unit_if.sv - decode inputs, hazard/ALU-flag inputs and staged control outputs
interface pipelined_control_unit_if #(
  parameter int ALU_CTRL_W = 4
);
  logic [6:0]            OP;
  logic [2:0]            funct3;
  logic                  funct75;
  logic                  StallE;
  logic                  FlushE;
  logic                  ZeroE;
  logic                  LtE;
  logic                  LtuE;
  logic [2:0]            ImmSrcD;
  logic                  RegWriteE;
  logic                  RegWriteM;
  logic                  RegWriteW;
  logic [1:0]            ResultSrcE;
  logic [1:0]            ResultSrcM;
  logic [1:0]            ResultSrcW;
  logic                  MemWriteE;
  logic                  MemWriteM;
  logic                  ALUSrcAE;
  logic                  ALUSrcBE;
  logic [ALU_CTRL_W-1:0] ALUControlE;
  logic                  PCSrcE;
  logic                  PCTargetSrcE;
  logic                  IllegalW;

  modport master (
    output OP, funct3, funct75, StallE, FlushE, ZeroE, LtE, LtuE,
    input  ImmSrcD, RegWriteE, RegWriteM, RegWriteW, ResultSrcE, ResultSrcM, ResultSrcW,
    input  MemWriteE, MemWriteM, ALUSrcAE, ALUSrcBE, ALUControlE, PCSrcE, PCTargetSrcE, IllegalW
  );

  modport slave (
    input  OP, funct3, funct75, StallE, FlushE, ZeroE, LtE, LtuE,
    output ImmSrcD, RegWriteE, RegWriteM, RegWriteW, ResultSrcE, ResultSrcM, ResultSrcW,
    output MemWriteE, MemWriteM, ALUSrcAE, ALUSrcBE, ALUControlE, PCSrcE, PCTargetSrcE, IllegalW
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - RV32I decode plus ID/EX, EX/MEM, MEM/WB control registers and branch resolve
module pipelined_control_unit #(
  parameter int ALU_CTRL_W   = 4,
  parameter int ILLEGAL_TRAP = 1
) (
  input logic                     CLK,
  input logic                     RST,
  pipelined_control_unit_if.slave ctl
);
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [3:0] alu_ctrl;
    logic       branch;
    logic       jump;
    logic       jump_reg;
    logic       illegal;
    logic [2:0] funct3;
  } id_ex_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       illegal;
  } ex_mem_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       illegal;
  } mem_wb_t;

  id_ex_t  dec;
  id_ex_t  ex;
  ex_mem_t mem;
  mem_wb_t wb;
  logic [2:0] imm_src_d;
  logic       cond;

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? 4'b0001 : 4'b0000;
      3'b001:  alu_op = 4'b0111;
      3'b010:  alu_op = 4'b0101;
      3'b011:  alu_op = 4'b0110;
      3'b100:  alu_op = 4'b0100;
      3'b101:  alu_op = alt ? 4'b1001 : 4'b1000;
      3'b110:  alu_op = 4'b0011;
      default: alu_op = 4'b0010;
    endcase
  endfunction

  always_comb begin
    dec        = '0;
    imm_src_d  = 3'b000;
    dec.funct3 = ctl.funct3;
    case (ctl.OP)
      7'b0000011: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b01;
        dec.alu_src_b  = 1'b1;
      end
      7'b0100011: begin
        dec.mem_write = 1'b1;
        dec.alu_src_b = 1'b1;
        imm_src_d     = 3'b001;
      end
      7'b0110011: begin
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = alu_op(ctl.funct3, ctl.funct75);
      end
      7'b0010011: begin
        // funct7[5] only distinguishes SRA/SRL among immediate ops; ADDI never becomes SUB
        dec.reg_write = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.alu_ctrl  = alu_op(ctl.funct3, (ctl.funct3 == 3'b101) && ctl.funct75);
      end
      7'b1100011: begin
        if (ctl.funct3[2:1] == 2'b01) begin
          dec.illegal = 1'b1;
        end else begin
          dec.branch   = 1'b1;
          dec.alu_ctrl = 4'b0001;
          imm_src_d    = 3'b010;
        end
      end
      7'b1101111: begin
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        imm_src_d      = 3'b011;
      end
      7'b1100111: begin
        dec.jump       = 1'b1;
        dec.jump_reg   = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        dec.alu_src_b  = 1'b1;
      end
      7'b0110111: begin
        dec.reg_write = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.alu_ctrl  = 4'b1010;
        imm_src_d     = 3'b100;
      end
      7'b0010111: begin
        dec.reg_write = 1'b1;
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1;
        imm_src_d     = 3'b100;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // A stalled E slot must not be forwarded into M, or its writes would happen twice
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else begin
      if (ctl.FlushE) begin
        ex <= '0;
      end else if (!ctl.StallE) begin
        ex <= dec;
      end
      if (ctl.StallE) begin
        mem <= '0;
      end else begin
        mem.reg_write  <= ex.reg_write;
        mem.result_src <= ex.result_src;
        mem.mem_write  <= ex.mem_write;
        mem.illegal    <= ex.illegal;
      end
      wb.reg_write  <= mem.reg_write;
      wb.result_src <= mem.result_src;
      wb.illegal    <= mem.illegal;
    end
  end

  always_comb begin
    cond = 1'b0;
    case (ex.funct3)
      3'b000:  cond = ctl.ZeroE;
      3'b001:  cond = !ctl.ZeroE;
      3'b100:  cond = ctl.LtE;
      3'b101:  cond = !ctl.LtE;
      3'b110:  cond = ctl.LtuE;
      3'b111:  cond = !ctl.LtuE;
      default: cond = 1'b0;
    endcase
  end

  assign ctl.ImmSrcD      = imm_src_d;
  assign ctl.RegWriteE    = ex.reg_write;
  assign ctl.RegWriteM    = mem.reg_write;
  assign ctl.RegWriteW    = wb.reg_write;
  assign ctl.ResultSrcE   = ex.result_src;
  assign ctl.ResultSrcM   = mem.result_src;
  assign ctl.ResultSrcW   = wb.result_src;
  assign ctl.MemWriteE    = ex.mem_write;
  assign ctl.MemWriteM    = mem.mem_write;
  assign ctl.ALUSrcAE     = ex.alu_src_a;
  assign ctl.ALUSrcBE     = ex.alu_src_b;
  assign ctl.ALUControlE  = ALU_CTRL_W'(ex.alu_ctrl);
  assign ctl.PCSrcE       = ex.jump | (ex.branch & cond);
  assign ctl.PCTargetSrcE = ex.jump_reg;
  assign ctl.IllegalW     = (ILLEGAL_TRAP != 0) ? wb.illegal : 1'b0;
endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Next-generation control path for the 5-stage RV32I core. It decodes OP/funct3/funct7[5] in Decode and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers, honouring hazard-unit stall and flush. It resolves all six RV32I branch conditions plus JAL/JALR in Execute and flags illegal opcodes. It replaces the purely combinational decoder plus the external control pipeline registers.

Parameters:
ALU_CTRL_W, 4, width of ALUControlE; must be >= 4; codes are zero-extended.
ILLEGAL_TRAP, 1, 1 = register and report illegal opcodes on IllegalW; 0 = IllegalW tied 0.

Ports:
CLK  in  1  core clock, rising edge.
RST  in  1  asynchronous active-low reset.
OP  in  7  instruction[6:0], Decode stage.
funct3  in  3  instruction[14:12], Decode stage.
funct75  in  1  instruction[30], Decode stage.
StallE  in  1  hold the ID/EX control register.
FlushE  in  1  load a bubble into ID/EX.
ZeroE  in  1  ALU result == 0.
LtE  in  1  signed SrcA < SrcB.
LtuE  in  1  unsigned SrcA < SrcB.
ImmSrcD  out  3  immediate format, combinational in D: I=000, S=001, B=010, J=011, U=100.
RegWriteE/M/W  out  1 each  register-file write enable per stage.
ResultSrcE/M/W  out  2 each  00 ALU, 01 memory, 10 PC+4.
MemWriteE/M  out  1 each  data-memory write enable.
ALUSrcAE  out  1  0 = rs1, 1 = PC.
ALUSrcBE  out  1  0 = rs2, 1 = immediate.
ALUControlE  out  ALU_CTRL_W  ALU operation.
PCSrcE  out  1  take branch or jump target (combinational in E).
PCTargetSrcE  out  1  0 = PC+imm, 1 = ALU result (JALR).
IllegalW  out  1  an illegal instruction reached Writeback.

Behaviour:
- Decode (combinational, D):
  - lw 0000011: RegWrite, ResultSrc=01, ALUSrcB, ADD, ImmSrc I.
  - sw 0100011: MemWrite, ALUSrcB, ADD, ImmSrc S.
  - R-type 0110011: RegWrite, ALU op from funct3/funct75.
  - I-ALU 0010011: RegWrite, ALUSrcB, ALU op from funct3; funct75 is honoured only for funct3=101 (SRA/SRL).
  - branch 1100011: Branch, SUB, ImmSrc B.
  - jal 1101111: Jump, RegWrite, ResultSrc=10, ImmSrc J.
  - jalr 1100111: Jump, JumpReg, RegWrite, ResultSrc=10, ALUSrcB, ADD, ImmSrc I.
  - lui 0110111: RegWrite, ALUSrcB, PASSB, ImmSrc U.
  - auipc 0010111: RegWrite, ALUSrcA, ALUSrcB, ADD, ImmSrc U.
- ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001, PASSB 1010.
- R-type funct3=000 with funct75=1 decodes to SUB; in I-ALU, funct3=000 is always ADD.
- Any other opcode is illegal: all enables 0, Illegal=1, ALU=ADD, ImmSrc=000.
- Pipeline registers:
  - ID/EX: on FlushE, load a bubble (all enables, Branch, Jump, JumpReg and Illegal = 0). Else on StallE, hold. Else load the D bundle. FlushE takes priority over StallE.
  - EX/MEM and MEM/WB always advance. When StallE=1, EX/MEM loads a bubble to avoid duplicate writes.
  - Latency: D to E = 1 cycle, E to M = 1, M to W = 1.
- Branch resolution (E):
  - cond: funct3E 000 Zero, 001 !Zero, 100 LtE, 101 !LtE, 110 LtuE, 111 !LtuE, 010/011 = 0 and mark illegal at decode.
  - PCSrcE = JumpE | (BranchE & cond).
  - PCTargetSrcE = JumpRegE.
  - A bubble in E forces PCSrcE=0.
- Reset: RST low asynchronously clears every pipeline register to the bubble. All registered outputs are 0 and PCSrcE=0 while reset is held. Reset mid-stream discards in-flight control.
- funct3 is carried in ID/EX for branch evaluation only.

Test Plan:
- Reset: drive OP=0110011, then assert RST=0 mid-cycle -> RegWriteE/M/W, MemWriteE/M and PCSrcE go 0 immediately and stay 0 until the first clock after release.
- Decode sweep: sub (OP=0110011, f3=000, f75=1) -> after 1 clk ALUControlE=0001, RegWriteE=1; srai (0010011, 101, 1) -> 1001 with ALUSrcBE=1; auipc -> ALUSrcAE=1 and ImmSrcD=100.
- Branches: bltu with LtuE=1 -> PCSrcE=1; bge with LtE=1 -> PCSrcE=0; bne with ZeroE=0 -> PCSrcE=1; jalr -> PCSrcE=1 and PCTargetSrcE=1.
- Pipeline propagation: lw issued at cycle n -> ResultSrcE=01 at n+1, ResultSrcM=01 at n+2, ResultSrcW=01 at n+3, RegWriteW=1 at n+3.
- Hazards: sw in E with StallE=1 -> ALUControlE held, MemWriteM=0 next cycle. StallE=1 and FlushE=1 together -> E becomes a bubble with PCSrcE=0 and MemWriteE=0.
- Illegal: OP=1111111 -> RegWrite/MemWrite=0 in every stage and IllegalW=1 exactly 3 cycles later. The same stimulus with ILLEGAL_TRAP=0 -> IllegalW=0.
